// File: rtl/fdivs_pkg.sv
// Shared types and constants for the fdivs_seq signed fractional divider.
package fdivs_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned ITER   = DATA_W;
  localparam int unsigned LAT    = ITER + 2;

  localparam logic [7:0] Q_MAX = 8'h7F;
  localparam logic [7:0] Q_MIN = 8'h80;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    DIV,
    FIX
  } state_e;

endpackage

// File: rtl/fdivs_step.sv
// One combinational restoring-division iteration: shift in a dividend bit,
// subtract the divisor magnitude when it fits, and emit the quotient bit.
module fdivs_step #(
  parameter int unsigned W = 9
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] div_i,
  input  logic         bit_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);

  logic [W:0] trial;

  always_comb begin
    trial = {rem_i, bit_i};
    q_o   = (trial >= {1'b0, div_i});
    rem_o = q_o ? W'(trial - {1'b0, div_i}) : trial[W-1:0];
  end

endmodule

// File: rtl/fdivs_seq.sv
// Sequential signed 1.15 / 1.7 fractional divider (inverse of FMULS).
// Optional FDIVS_ROUND_EN: round quotient to nearest, ties away from zero.
module fdivs_seq #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ITER   = DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_r1,
  input  logic [DATA_W-1:0] i_r0,
  input  logic [DATA_W-1:0] i_rr,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_q,
  output logic [DATA_W-1:0] o_rem,
  output logic              o_ovf,
  output logic              o_dbz
);

  import fdivs_pkg::*;

  localparam int unsigned PW    = 2 * DATA_W;
  localparam int unsigned RW    = DATA_W + 1;
  localparam int unsigned CNT_W = $clog2(ITER + 1);

  state_e              state_q;
  logic [PW-1:0]       prod_q;
  logic [DATA_W-1:0]   rr_q;
  logic [RW-1:0]       acc_q;
  logic [RW-1:0]       vmag_q;
  logic [DATA_W-1:0]   sh_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                dbz_q, ovf_q;
  logic                busy_q, done_q;
  logic [DATA_W-1:0]   q_q, rem_q;
  logic                ovf_o_q, dbz_o_q;

  // CHECK-stage magnitudes and error flags
  logic signed [PW-1:0] d_s;
  logic [PW:0]          d_ext, dmag;
  logic [RW-1:0]        v_ext, vmag;
  logic                 dbz_c, ovf_c;

  always_comb begin
    d_s   = $signed(prod_q) >>> 1;
    d_ext = {d_s[PW-1], d_s};
    dmag  = d_ext[PW] ? -d_ext : d_ext;
    v_ext = {rr_q[DATA_W-1], rr_q};
    vmag  = v_ext[RW-1] ? -v_ext : v_ext;
    dbz_c = (rr_q == '0);
    ovf_c = !dbz_c && (dmag >= {1'b0, vmag, {(DATA_W-1){1'b0}}});
  end

  logic [RW-1:0] step_rem;
  logic          step_q;

  fdivs_step #(.W(RW)) u_step (
    .rem_i (acc_q),
    .div_i (vmag_q),
    .bit_i (sh_q[DATA_W-1]),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  // FIX-stage result selection
  logic              neg_d, neg_q;
  logic [DATA_W-1:0] qmag;
  logic [DATA_W-1:0] q_d, rem_d;
  logic              ovf_d;

  always_comb begin
    neg_d = prod_q[PW-1];
    neg_q = neg_d ^ rr_q[DATA_W-1];
    qmag  = sh_q;
    q_d   = '0;
    rem_d = '0;
    ovf_d = 1'b0;
    if (dbz_q) begin
      q_d = neg_d ? Q_MIN : Q_MAX;
    end else if (ovf_q) begin
      q_d   = neg_q ? Q_MIN : Q_MAX;
      ovf_d = 1'b1;
    end else begin
`ifdef FDIVS_ROUND_EN
      if ({acc_q, 1'b0} >= {1'b0, vmag_q}) qmag = qmag + DATA_W'(1);
`endif
      // qmag is below 128 here unless rounding carried it up to exactly 128
      if (qmag[DATA_W-1]) begin
        q_d   = neg_q ? Q_MIN : Q_MAX;
        ovf_d = 1'b1;
      end else begin
        q_d = neg_q ? -qmag : qmag;
      end
      rem_d = neg_d ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      prod_q  <= '0;
      rr_q    <= '0;
      acc_q   <= '0;
      vmag_q  <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
      rem_q   <= '0;
      ovf_o_q <= 1'b0;
      dbz_o_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            prod_q  <= {i_r1, i_r0};
            rr_q    <= i_rr;
            busy_q  <= 1'b1;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          acc_q   <= dmag[PW:DATA_W];
          sh_q    <= dmag[DATA_W-1:0];
          vmag_q  <= vmag;
          dbz_q   <= dbz_c;
          ovf_q   <= ovf_c;
          cnt_q   <= CNT_W'(ITER - 1);
          state_q <= DIV;
        end
        DIV: begin
          // sh_q shifts dividend bits out and quotient bits in
          acc_q <= step_rem;
          sh_q  <= {sh_q[DATA_W-2:0], step_q};
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == '0) state_q <= FIX;
        end
        FIX: begin
          q_q     <= q_d;
          rem_q   <= rem_d;
          ovf_o_q <= ovf_d;
          dbz_o_q <= dbz_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_q    = q_q;
  assign o_rem  = rem_q;
  assign o_ovf  = ovf_o_q;
  assign o_dbz  = dbz_o_q;

endmodule

// File: tb/tb_fdivs_seq.sv
// Self-checking bench for fdivs_seq against an integer-arithmetic reference.
module tb_fdivs_seq;
  import fdivs_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] r1 = '0, r0 = '0, rr = '0;
  logic       busy, done, ovf, dbz;
  logic [7:0] q, rem;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fdivs_seq #(.DATA_W(8), .ITER(8)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_r1    (r1),
    .i_r0    (r0),
    .i_rr    (rr),
    .o_busy  (busy),
    .o_done  (done),
    .o_q     (q),
    .o_rem   (rem),
    .o_ovf   (ovf),
    .o_dbz   (dbz)
  );

`ifdef FDIVS_ROUND_EN
  localparam logic [7:0] Q_RND_CASE = 8'h08;
`else
  localparam logic [7:0] Q_RND_CASE = 8'h07;
`endif

  // Reference: plain signed integer division with the saturation rules.
  task automatic model(input logic [15:0] p, input logic [7:0] r,
                       output logic [7:0] eq, output logic [7:0] erem,
                       output logic eovf, output logic edbz);
    int d, v, ad, av, qt, rt, mag;
    bit neg;
    d = $signed(p);
    d = d >>> 1;
    v = $signed(r);
    neg  = (d < 0) != (v < 0);
    eovf = 1'b0;
    edbz = 1'b0;
    erem = '0;
    if (v == 0) begin
      edbz = 1'b1;
      eq   = (d >= 0) ? 8'h7F : 8'h80;
    end else begin
      ad = (d < 0) ? -d : d;
      av = (v < 0) ? -v : v;
      if (ad >= 128 * av) begin
        eovf = 1'b1;
        eq   = neg ? 8'h80 : 8'h7F;
      end else begin
        qt  = d / v;
        rt  = d % v;
        mag = (qt < 0) ? -qt : qt;
`ifdef FDIVS_ROUND_EN
        if (2 * ((rt < 0) ? -rt : rt) >= av) mag++;
`endif
        if (mag >= 128) begin
          eovf = 1'b1;
          eq   = neg ? 8'h80 : 8'h7F;
        end else begin
          eq = 8'(neg ? -mag : mag);
        end
        erem = 8'(rt);
      end
    end
  endtask

  // Issue one request, scramble inputs while busy, return edges until o_done.
  task automatic run_op(input logic [15:0] p, input logic [7:0] r, output int lat);
    @(negedge clk);
    {r1, r0} = p;
    rr    = r;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    while (done !== 1'b1 && lat < 40) begin
      {r1, r0, rr} = 24'($urandom);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL reset_q got=%h exp=00", q); end
    n_cmp++; if (rem !== 8'h00) begin n_err++; $display("FAIL reset_rem got=%h exp=00", rem); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    n_cmp++; if (dbz !== 1'b0) begin n_err++; $display("FAIL reset_dbz got=%b exp=0", dbz); end
    rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [15:0] tp [7] = '{16'h2000, 16'hE000, 16'hFF9C, 16'h2000, 16'hE000, 16'h8000, 16'h006A};
    logic [7:0]  tr [7] = '{8'h40, 8'hC0, 8'h07, 8'h00, 8'h00, 8'h80, 8'h07};
    logic [7:0]  tq [7] = '{8'h40, 8'h40, 8'hF9, 8'h7F, 8'h80, 8'h7F, Q_RND_CASE};
    logic [7:0]  tm [7] = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h04};
    logic        to [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        tz [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int lat;
    for (int i = 0; i < 7; i++) begin
      run_op(tp[i], tr[i], lat);
      n_cmp++; if (lat != LAT) begin n_err++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, LAT); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL dir%0d_busy_at_done got=%b exp=0", i, busy); end
      n_cmp++; if (q !== tq[i]) begin n_err++; $display("FAIL dir%0d_q got=%h exp=%h", i, q, tq[i]); end
      n_cmp++; if (rem !== tm[i]) begin n_err++; $display("FAIL dir%0d_rem got=%h exp=%h", i, rem, tm[i]); end
      n_cmp++; if (ovf !== to[i]) begin n_err++; $display("FAIL dir%0d_ovf got=%b exp=%b", i, ovf, to[i]); end
      n_cmp++; if (dbz !== tz[i]) begin n_err++; $display("FAIL dir%0d_dbz got=%b exp=%b", i, dbz, tz[i]); end
      @(negedge clk);
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL dir%0d_done_pulse got=%b exp=0", i, done); end
      n_cmp++; if (q !== tq[i]) begin n_err++; $display("FAIL dir%0d_q_hold got=%h exp=%h", i, q, tq[i]); end
    end
  endtask

  task automatic test_random;
    logic [15:0] p;
    logic [7:0]  r, eq, erem;
    logic        eovf, edbz;
    int lat;
    for (int i = 0; i < 300; i++) begin
      r = 8'($urandom);
      case ($urandom_range(0, 3))
        0: p = 16'($urandom);
        1: p = 16'($signed(10'($urandom)));
        2: p = 16'($signed(13'($urandom)));
        default: begin
          p = 16'($signed(r) * $signed(8'($urandom))) << 1;
          if ($urandom_range(0, 7) == 0) r = '0;
        end
      endcase
      model(p, r, eq, erem, eovf, edbz);
      run_op(p, r, lat);
      n_cmp++; if (lat != LAT) begin n_err++; $display("FAIL rnd_latency p=%h r=%h got=%0d exp=%0d", p, r, lat, LAT); end
      n_cmp++; if (q !== eq) begin n_err++; $display("FAIL rnd_q p=%h r=%h got=%h exp=%h", p, r, q, eq); end
      n_cmp++; if (rem !== erem) begin n_err++; $display("FAIL rnd_rem p=%h r=%h got=%h exp=%h", p, r, rem, erem); end
      n_cmp++; if (ovf !== eovf) begin n_err++; $display("FAIL rnd_ovf p=%h r=%h got=%b exp=%b", p, r, ovf, eovf); end
      n_cmp++; if (dbz !== edbz) begin n_err++; $display("FAIL rnd_dbz p=%h r=%h got=%b exp=%b", p, r, dbz, edbz); end
    end
  endtask

  task automatic test_ignore_start;
    int lat, pulses;
    @(negedge clk);
    {r1, r0} = 16'h2000;
    rr    = 8'h40;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    while (done !== 1'b1 && lat < 40) begin
      start = (lat == 3 || lat == 7);
      {r1, r0, rr} = 24'h800080;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    n_cmp++; if (lat != LAT) begin n_err++; $display("FAIL ign_latency got=%0d exp=%0d", lat, LAT); end
    n_cmp++; if (q !== 8'h40) begin n_err++; $display("FAIL ign_q got=%h exp=40", q); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ign_ovf got=%b exp=0", ovf); end
    pulses = 0;
    repeat (14) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL ign_no_queued_op got=%0d exp=0", pulses); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] pa, pb;
    logic [7:0]  ra, rb, eq, erem;
    logic        eovf, edbz;
    int lat;
    for (int k = 0; k < 4; k++) begin
      pa = 16'($signed(9'($urandom)));
      ra = 8'($urandom_range(1, 127));
      pb = 16'($urandom);
      rb = 8'($urandom);
      model(pa, ra, eq, erem, eovf, edbz);
      run_op(pa, ra, lat);
      n_cmp++; if (lat != LAT) begin n_err++; $display("FAIL b2b_a_latency got=%0d exp=%0d", lat, LAT); end
      n_cmp++; if (q !== eq || rem !== erem) begin n_err++; $display("FAIL b2b_a_result got=%h/%h exp=%h/%h", q, rem, eq, erem); end
      {r1, r0} = pb;
      rr    = rb;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept_busy got=%b exp=1", busy); end
      model(pb, rb, eq, erem, eovf, edbz);
      lat = 0;
      while (done !== 1'b1 && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      n_cmp++; if (lat != LAT) begin n_err++; $display("FAIL b2b_b_latency got=%0d exp=%0d", lat, LAT); end
      n_cmp++; if (q !== eq || rem !== erem || ovf !== eovf || dbz !== edbz)
        begin n_err++; $display("FAIL b2b_b_result got=%h/%h/%b/%b exp=%h/%h/%b/%b", q, rem, ovf, dbz, eq, erem, eovf, edbz); end
    end
  endtask

  task automatic test_reset_mid;
    int lat, pulses;
    run_op(16'hFF9C, 8'h07, lat);
    n_cmp++; if (q !== 8'hF9 || rem !== 8'hFF) begin n_err++; $display("FAIL rstmid_pre got=%h/%h exp=F9/FF", q, rem); end
    @(negedge clk);
    {r1, r0} = 16'h2000;
    rr    = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    n_cmp++; if (q !== 8'h00 || rem !== 8'h00) begin n_err++; $display("FAIL rstmid_data got=%h/%h exp=00/00", q, rem); end
    n_cmp++; if (ovf !== 1'b0 || dbz !== 1'b0) begin n_err++; $display("FAIL rstmid_flags got=%b/%b exp=0/0", ovf, dbz); end
    rst = 1'b0;
    pulses = 0;
    repeat (15) begin
      if (done === 1'b1) pulses++;
      @(negedge clk);
    end
    n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL rstmid_no_done got=%0d exp=0", pulses); end
    run_op(16'h2000, 8'h40, lat);
    n_cmp++; if (lat != LAT || q !== 8'h40) begin n_err++; $display("FAIL rstmid_recover got=%0d/%h exp=%0d/40", lat, q, LAT); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
